serial_full_subtractor: RTL and testbench

- Bit-serial subtractor that computes diff = a - b - b_in over WIDTH cycles.
- Uses one full-subtractor cell and a registered borrow, processing operands LSB-first.
- It is the inverse-direction companion to the full-adder datapath blocks, intended for area-constrained arithmetic paths.
- Operands are loaded in parallel on a start handshake; the result is presented in parallel with a one-cycle done pulse.

---
 rtl/serial_full_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_full_subtractor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_full_subtractor.sv
// Bit-serial a - b - b_in, one full-subtractor cell, LSB first.
// Result is shifted into the vacated MSBs of the minuend register.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;

  assign w_ai      = r_a[0];
  assign w_bi      = r_b[0];
  assign w_d       = w_ai ^ w_bi ^ r_br;
  assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_last    = (r_cnt == 6'(WIDTH - 1));
  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_next = w_d;
      assign w_b_next = 1'b0;
    end else begin : g_wn
      assign w_a_next = {w_d, r_a[WIDTH-1:1]};
      assign w_b_next = {1'b0, r_b[WIDTH-1:1]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and status outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? SHIFT : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand load, per-bit step and result capture on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= b_in;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= w_a_next;
      r_b   <= w_b_next;
      r_br  <= w_br_next;
      r_cnt <= r_cnt + 6'd1;
      if (w_last) begin
        r_diff <= w_a_next;
        r_bout <= w_br_next;
        r_ovf  <= r_br ^ w_br_next;
      end
    end
  end

  assign diff  = r_diff;
  assign b_out = r_bout;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Bench for serial_full_subtractor: table vectors, random ops
// against an arithmetic model, and multi-cycle corner sequences.
module tb_serial_full_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1, ovf1;
  logic [0:0] diff1;

  int total = 0;
  int bad = 0;
  int ovl = 0;

  always #5 clk = ~clk;

  serial_full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8), .b_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8),
    .b_out(bout8), .ovf(ovf8)
  );

  serial_full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .b_in(bin1),
    .busy(busy1), .done(done1), .diff(diff1),
    .b_out(bout1), .ovf(ovf1)
  );

  always @(negedge clk) begin
    if ((busy8 && done8) || (busy1 && done1)) ovl++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input int w, input int a, input int b,
                                input int bi, output int d,
                                output int bo, output int ov);
    int r;
    int sa;
    int sb;
    int sr;
    int half;
    half = 1 << (w - 1);
    r  = a - b - bi;
    d  = r & ((1 << w) - 1);
    bo = (r < 0) ? 1 : 0;
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    sr = sa - sb - bi;
    ov = (sr < -half || sr > half - 1) ? 1 : 0;
  endfunction

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                     input logic ibi, output int dv, output int bo,
                     output int ov, output int nbusy, output int tdone);
    @(negedge clk);
    a8 = ia; b8 = ib; bin8 = ibi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    nbusy = 0;
    tdone = -1;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        tdone = i;
        break;
      end
      if (busy8) nbusy++;
      @(negedge clk);
    end
    dv = diff8; bo = bout8; ov = ovf8;
  endtask

  task automatic op1(input logic ia, input logic ib, input logic ibi,
                     output int dv, output int bo, output int ov,
                     output int tdone);
    @(negedge clk);
    a1 = ia; b1 = ib; bin1 = ibi; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    tdone = -1;
    for (int i = 0; i < 10; i++) begin
      if (done1) begin
        tdone = i;
        break;
      end
      @(negedge clk);
    end
    dv = diff1; bo = bout1; ov = ovf1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t tbl[5];
  logic [1:0] exp1[8];

  initial begin
    int dv, bo, ov, nb, td;
    int md, mbo, mov;
    int t1, t2, d1, bz9, ndone;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    exp1 = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_bout", bout8, 0);
    chk("rst_ovf", ovf8, 0);

    foreach (tbl[i]) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].bi, dv, bo, ov, nb, td);
      chk($sformatf("tbl%0d_diff", i), dv, tbl[i].d);
      chk($sformatf("tbl%0d_bout", i), bo, tbl[i].bo);
      chk($sformatf("tbl%0d_ovf", i), ov, tbl[i].ov);
      chk($sformatf("tbl%0d_busycyc", i), nb, 8);
      chk($sformatf("tbl%0d_donelat", i), td, 8);
      @(negedge clk);
      chk($sformatf("tbl%0d_donepulse", i), done8, 0);
    end

    for (int i = 0; i < 8; i++) begin
      op1(i[2], i[1], i[0], dv, bo, ov, td);
      model(1, i[2], i[1], i[0], md, mbo, mov);
      chk($sformatf("w1_%0d_diff_bout", i), {dv[0], bo[0]}, exp1[i]);
      chk($sformatf("w1_%0d_ovf", i), ov, mov);
      chk($sformatf("w1_%0d_lat", i), td, 1);
    end

    for (int n = 0; n < 25; n++) begin
      logic [7:0] ra, rb;
      logic rbi;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rbi = 1'($urandom);
      op8(ra, rb, rbi, dv, bo, ov, nb, td);
      model(8, ra, rb, rbi, md, mbo, mov);
      chk($sformatf("rnd%0d_diff", n), dv, md);
      chk($sformatf("rnd%0d_bout", n), bo, mbo);
      chk($sformatf("rnd%0d_ovf", n), ov, mov);
      chk($sformatf("rnd%0d_lat", n), td, 8);
    end

    // start held high for 12 cycles
    @(negedge clk);
    a8 = 8'h0A; b8 = 8'h04; bin8 = 1'b0; start8 = 1'b1;
    t1 = -1; t2 = -1; d1 = -1; bz9 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 11) start8 = 1'b0;
      if (i == 9) bz9 = busy8;
      if (done8) begin
        if (t1 < 0) begin
          t1 = i;
          d1 = diff8;
        end else if (t2 < 0) begin
          t2 = i;
        end
      end
    end
    chk("hold_first_done", t1, 8);
    chk("hold_first_diff", d1, 8'h06);
    chk("hold_busy_after_done", bz9, 1);
    chk("hold_second_done", t2, 17);
    chk("hold_second_diff", diff8, 8'h06);

    // reset in the middle of an operation
    op8(8'h7F, 8'hFF, 1'b0, dv, bo, ov, nb, td);
    chk("pre_rst_bout", bo, 1);
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_diff", diff8, 0);
    chk("abort_bout", bout8, 0);
    chk("abort_ovf", ovf8, 0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_diff_hold", diff8, 0);
    op8(8'h10, 8'h01, 1'b0, dv, bo, ov, nb, td);
    chk("post_rst_diff", dv, 8'h0F);
    chk("post_rst_lat", td, 8);

    chk("busy_done_overlap", ovl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
